alu_input_stage: RTL and testbench
==================================

ALU_INPUT_STAGE -- requirements
Module: alu_input_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of every stream data word.
REQ-002 Parameter OPCODE_WIDTH, default 6, opcode field = operator data[OPCODE_WIDTH-1:0]; data[DATA_WIDTH-1:OPCODE_WIDTH] = copy count, passed through untouched.
REQ-003 Parameter ALU_OP_MAX, default 6'd19, highest legal opcode value.
REQ-004 clock  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_operator  data_interface.consumer  DATA_WIDTH  operator words from the instruction source.
REQ-007 in_left  data_interface.consumer  DATA_WIDTH  left operand words.
REQ-008 in_right  data_interface.consumer  DATA_WIDTH  right operand words.
REQ-009 out_operator  data_interface.producer  DATA_WIDTH  operator words toward the ALU operator port.
REQ-010 out_left  data_interface.producer  DATA_WIDTH  left operands toward the ALU.
REQ-011 out_right  data_interface.producer  DATA_WIDTH  right operands toward the ALU.
REQ-012 illegal_count  output  16  number of dropped operator words (present only with ALU_INPUT_DROP_ILLEGAL_EN).

Function
REQ-013 Each channel (operator, left, right) SHALL be an independent 2-entry buffer with states EMPTY, ONE, TWO; channels never stall each other.
REQ-014 Transfer occurs on a channel when valid && ack in the same cycle; data SHALL be held stable while valid && !ack.
REQ-015 in_*.ack SHALL be driven only from registered state: ack = (state != TWO); no combinational path from out_*.ack to in_*.ack.
REQ-016 out_*.valid = (state != EMPTY); out_*.data = head entry register; no combinational path from in_* to out_*.
REQ-017 Latency: word accepted in cycle N appears on out_* in cycle N+1 when the buffer was EMPTY.
REQ-018 Transitions: push only -> EMPTY->ONE, ONE->TWO; pop only -> TWO->ONE, ONE->EMPTY; push and pop in ONE -> stay ONE with the new word as head; pop in TWO with push impossible (ack low).
REQ-019 Ordering SHALL be strict FIFO per channel; no word duplicated or lost except per REQ-021.
REQ-020 Full throughput: with out_*.ack held high, one word per cycle per channel sustained indefinitely.

Reset
REQ-024 While reset is high all channel states SHALL be EMPTY, all out_*.valid 0, all in_*.ack 0, out_*.data 0, illegal_count 0.
REQ-025 Reset asserted mid-transfer SHALL discard all buffered words immediately, without waiting for a clock edge.
REQ-026 in_*.ack SHALL rise on the first rising clock edge after reset deasserts.

Configuration
REQ-021 With ALU_INPUT_DROP_ILLEGAL_EN defined: an operator word whose opcode > ALU_OP_MAX SHALL be acked (when state != TWO) but not stored, and illegal_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-022 With ALU_INPUT_DROP_ILLEGAL_EN defined: legal opcodes and the left/right channels SHALL be unaffected, and a drop SHALL not consume any left/right operand.
REQ-023 Without ALU_INPUT_DROP_ILLEGAL_EN: every operator word SHALL be forwarded unchanged, and the illegal_count port and its counter SHALL not exist.

Verification
REQ-027 Reset, then push operator 0x00000051 (opcode 17, count 1), left 7, right 6 with out_*.ack high -> each out_* valid exactly one cycle later with 0x51, 7, 6.
REQ-028 Hold out_left.ack low, push 3 left words A,B,C -> A,B accepted, in_left.ack low after B; C accepted one cycle after the first pop; outputs A,B,C in order.
REQ-029 Random valid on inputs and random ack on outputs for 10000 cycles -> per-channel output sequence equals input sequence; in_*.ack never depends combinationally on out_*.ack.
REQ-030 With macro: push opcodes 5, 63, 20, 9 -> out_operator carries 5, 9 only; illegal_count = 2; left/right untouched.
REQ-031 Without macro: same stimulus -> out_operator carries 5, 63, 20, 9.
REQ-032 Fill all channels to TWO, assert reset between edges -> out_*.valid 0 immediately; after release, no stale words are emitted.

Source files
------------

// File: rtl/alu_input_stage.sv
// Three independent 2-entry skid buffers (operator, left, right) in front of the ALU.
// Optional macro ALU_INPUT_DROP_ILLEGAL_EN drops out-of-range opcodes and counts them.
module alu_input_stage #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned ALU_OP_MAX   = 19
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_operator_valid,
  input  logic [DATA_WIDTH-1:0] in_operator_data,
  output logic                  in_operator_ack,
  input  logic                  in_left_valid,
  input  logic [DATA_WIDTH-1:0] in_left_data,
  output logic                  in_left_ack,
  input  logic                  in_right_valid,
  input  logic [DATA_WIDTH-1:0] in_right_data,
  output logic                  in_right_ack,
  output logic                  out_operator_valid,
  output logic [DATA_WIDTH-1:0] out_operator_data,
  input  logic                  out_operator_ack,
  output logic                  out_left_valid,
  output logic [DATA_WIDTH-1:0] out_left_data,
  input  logic                  out_left_ack,
  output logic                  out_right_valid,
  output logic [DATA_WIDTH-1:0] out_right_data,
  input  logic                  out_right_ack
`ifdef ALU_INPUT_DROP_ILLEGAL_EN
  ,
  output logic [15:0]           illegal_count
`endif
);

  localparam int unsigned NumCh = 3;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} ch_state_e;

  if (OPCODE_WIDTH >= DATA_WIDTH || ALU_OP_MAX >= (1 << OPCODE_WIDTH)) begin : g_bad_cfg
    $error("alu_input_stage: OPCODE_WIDTH/ALU_OP_MAX inconsistent with DATA_WIDTH");
  end

  logic [NumCh-1:0]                 in_valid, in_ack, out_valid, out_ack, drop;
  logic [NumCh-1:0][DATA_WIDTH-1:0] in_data, out_data;
  logic                             rdy_q, rdy_d;

  assign in_valid = {in_right_valid, in_left_valid, in_operator_valid};
  assign in_data  = {in_right_data, in_left_data, in_operator_data};
  assign out_ack  = {out_right_ack, out_left_ack, out_operator_ack};

  assign in_operator_ack    = in_ack[0];
  assign in_left_ack        = in_ack[1];
  assign in_right_ack       = in_ack[2];
  assign out_operator_valid = out_valid[0];
  assign out_left_valid     = out_valid[1];
  assign out_right_valid    = out_valid[2];
  assign out_operator_data  = out_data[0];
  assign out_left_data      = out_data[1];
  assign out_right_data     = out_data[2];

  // Holds acks low until the first clock edge after reset release.
  assign rdy_d = 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
    end
  end

`ifdef ALU_INPUT_DROP_ILLEGAL_EN
  logic        op_illegal;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  always_comb begin
    op_illegal    = 32'(in_operator_data[OPCODE_WIDTH-1:0]) > ALU_OP_MAX;
    drop          = {2'b00, op_illegal};
    illegal_cnt_d = illegal_cnt_q;
    if (in_operator_valid && in_ack[0] && op_illegal && (illegal_cnt_q != 16'hFFFF)) begin
      illegal_cnt_d = illegal_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_cnt_q <= '0;
    end else begin
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign illegal_count = illegal_cnt_q;
`else
  assign drop = '0;
`endif

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    ch_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic                  push, pop, valid, ack;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= StEmpty;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        state_q <= state_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
      end
    end

    always_comb begin
      push    = in_valid[c] && ack && !drop[c];
      pop     = valid && out_ack[c];
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
        StEmpty: begin
          if (push) begin
            state_d = StOne;
            head_d  = in_data[c];
          end
        end
        StOne: begin
          if (push && pop) begin
            head_d = in_data[c];
          end else if (push) begin
            state_d = StTwo;
            tail_d  = in_data[c];
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          // ack is low here, so only a pop can happen.
          if (pop) begin
            state_d = StOne;
            head_d  = tail_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    always_comb begin
      valid = (state_q != StEmpty);
      ack   = rdy_q && (state_q != StTwo);
    end

    assign out_valid[c] = valid;
    assign in_ack[c]    = ack;
    assign out_data[c]  = head_q;
  end

endmodule

// File: tb/tb_alu_input_stage.sv
// Self-checking bench for alu_input_stage: directed scenarios plus a randomized
// run checked against per-channel FIFO queues.
module tb_alu_input_stage;

  localparam int DW = 32;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [2:0]          in_valid, in_ack, out_valid, out_ack;
  logic [2:0][DW-1:0]  in_data, out_data;
`ifdef ALU_INPUT_DROP_ILLEGAL_EN
  logic [15:0]         illegal_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  alu_input_stage dut (
    .clock              (clock),
    .reset              (reset),
    .in_operator_valid  (in_valid[0]),
    .in_operator_data   (in_data[0]),
    .in_operator_ack    (in_ack[0]),
    .in_left_valid      (in_valid[1]),
    .in_left_data       (in_data[1]),
    .in_left_ack        (in_ack[1]),
    .in_right_valid     (in_valid[2]),
    .in_right_data      (in_data[2]),
    .in_right_ack       (in_ack[2]),
    .out_operator_valid (out_valid[0]),
    .out_operator_data  (out_data[0]),
    .out_operator_ack   (out_ack[0]),
    .out_left_valid     (out_valid[1]),
    .out_left_data      (out_data[1]),
    .out_left_ack       (out_ack[1]),
    .out_right_valid    (out_valid[2]),
    .out_right_data     (out_data[2]),
    .out_right_ack      (out_ack[2])
`ifdef ALU_INPUT_DROP_ILLEGAL_EN
    ,
    .illegal_count      (illegal_count)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    in_valid = '0;
    in_data  = '0;
    out_ack  = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    in_valid = '0;
    in_data  = '0;
    out_ack  = '0;
    reset    = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_valid: got %b need 000", out_valid);
    end
    n_checks++;
    if (in_ack !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ack: got %b need 000", in_ack);
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h need 0", out_data);
    end
`ifdef ALU_INPUT_DROP_ILLEGAL_EN
    n_checks++;
    if (illegal_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d need 0", illegal_count);
    end
`endif
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ack !== 3'b000) begin
      n_fail++;
      $display("FAIL ack_before_edge: got %b need 000", in_ack);
    end
    tick();
    n_checks++;
    if (in_ack !== 3'b111) begin
      n_fail++;
      $display("FAIL ack_after_edge: got %b need 111", in_ack);
    end
  endtask

  task automatic test_latency();
    logic [2:0][DW-1:0] exp;
    exp      = {32'd6, 32'd7, 32'h51};
    out_ack  = 3'b111;
    in_valid = 3'b111;
    in_data  = exp;
    #1;
    n_checks++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL latency_early: got %b need 000", out_valid);
    end
    tick();
    in_valid = '0;
    n_checks++;
    if (out_valid !== 3'b111) begin
      n_fail++;
      $display("FAIL latency_valid: got %b need 111", out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_data[c] !== exp[c]) begin
        n_fail++;
        $display("FAIL latency_data ch%0d: got %h need %h", c, out_data[c], exp[c]);
      end
    end
    tick();
    n_checks++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL latency_one_cycle: got %b need 000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] wa, wb, wc;
    wa = 32'hA;
    wb = 32'hB;
    wc = 32'hC;
    out_ack     = 3'b101;
    in_valid[1] = 1'b1;
    in_data[1]  = wa;
    tick();
    in_data[1] = wb;
    n_checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== wa || in_ack[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_after_a: got v=%b d=%h ack=%b need v=1 d=%h ack=1",
               out_valid[1], out_data[1], in_ack[1], wa);
    end
    tick();
    in_data[1] = wc;
    n_checks++;
    if (in_ack[1] !== 1'b0 || out_data[1] !== wa) begin
      n_fail++;
      $display("FAIL bp_full: got ack=%b d=%h need ack=0 d=%h", in_ack[1], out_data[1], wa);
    end
    out_ack[1] = 1'b1;
    tick();
    n_checks++;
    if (in_ack[1] !== 1'b1 || out_data[1] !== wb) begin
      n_fail++;
      $display("FAIL bp_after_pop: got ack=%b d=%h need ack=1 d=%h", in_ack[1], out_data[1], wb);
    end
    tick();
    in_valid[1] = 1'b0;
    n_checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== wc) begin
      n_fail++;
      $display("FAIL bp_c: got v=%b d=%h need v=1 d=%h", out_valid[1], out_data[1], wc);
    end
    tick();
    n_checks++;
    if (out_valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%b need 0", out_valid[1]);
    end
  endtask

  task automatic test_illegal();
    logic [5:0]    ops [4];
    logic [DW-1:0] got [$];
    logic [DW-1:0] exp [$];
    logic [DW-1:0] w;
    bit            side_seen;
    ops = '{6'd5, 6'd63, 6'd20, 6'd9};
    side_seen = 1'b0;
    apply_reset();
    out_ack = 3'b111;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[0]) got.push_back(out_data[0]);
      if (out_valid[2:1] !== 2'b00) side_seen = 1'b1;
      if (i < 4) begin
        w          = {26'(i + 1), ops[i]};
        in_valid[0] = 1'b1;
        in_data[0]  = w;
`ifdef ALU_INPUT_DROP_ILLEGAL_EN
        if (ops[i] <= 6'd19) exp.push_back(w);
`else
        exp.push_back(w);
`endif
      end else begin
        in_valid[0] = 1'b0;
      end
      tick();
    end
    n_checks++;
    if (got.size() != exp.size()) begin
      n_fail++;
      $display("FAIL illegal_len: got %0d words need %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (got[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL illegal_word%0d: got %h need %h", i, got[i], exp[i]);
        end
      end
    end
    n_checks++;
    if (side_seen) begin
      n_fail++;
      $display("FAIL illegal_side: got left/right output activity need none");
    end
`ifdef ALU_INPUT_DROP_ILLEGAL_EN
    n_checks++;
    if (illegal_count !== 16'd2) begin
      n_fail++;
      $display("FAIL illegal_count: got %0d need 2", illegal_count);
    end
`endif
  endtask

  task automatic test_random();
    logic [DW-1:0] mq [3][$];
    logic [2:0]    ack_snap;
    int            drops;
    drops = 0;
    apply_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (out_valid[c] !== (mq[c].size() > 0)) begin
          n_fail++;
          $display("FAIL rnd_valid ch%0d cyc%0d: got %b need %0d", c, cyc, out_valid[c],
                   mq[c].size() > 0);
        end else if (mq[c].size() > 0) begin
          n_checks++;
          if (out_data[c] !== mq[c][0]) begin
            n_fail++;
            $display("FAIL rnd_data ch%0d cyc%0d: got %h need %h", c, cyc, out_data[c],
                     mq[c][0]);
          end
        end
        n_checks++;
        if (in_ack[c] !== (mq[c].size() < 2)) begin
          n_fail++;
          $display("FAIL rnd_ack ch%0d cyc%0d: got %b need %0d", c, cyc, in_ack[c],
                   mq[c].size() < 2);
        end
      end
      for (int c = 0; c < 3; c++) begin
        // A stalled word must stay put until it is taken.
        if (!(in_valid[c] && !in_ack[c])) begin
          in_valid[c] = ($urandom_range(3, 0) != 0);
          in_data[c]  = $urandom;
          if (c == 0) begin
            if ($urandom_range(7, 0) == 0) in_data[0][5:0] = 6'($urandom_range(63, 20));
            else                           in_data[0][5:0] = 6'($urandom_range(19, 0));
          end
        end
        out_ack[c] = $urandom_range(1, 0) == 1;
      end
      #1;
      ack_snap = in_ack;
      out_ack  = ~out_ack;
      #1;
      n_checks++;
      if (in_ack !== ack_snap) begin
        n_fail++;
        $display("FAIL rnd_ack_comb cyc%0d: got %b need %b", cyc, in_ack, ack_snap);
      end
      out_ack = ~out_ack;
      #1;
      for (int c = 0; c < 3; c++) begin
        if (out_valid[c] && out_ack[c]) void'(mq[c].pop_front());
        if (in_valid[c] && in_ack[c]) begin
`ifdef ALU_INPUT_DROP_ILLEGAL_EN
          if (c == 0 && in_data[0][5:0] > 6'd19) drops++;
          else mq[c].push_back(in_data[c]);
`else
          mq[c].push_back(in_data[c]);
`endif
        end
      end
      @(posedge clock);
      #1;
    end
`ifdef ALU_INPUT_DROP_ILLEGAL_EN
    n_checks++;
    if (illegal_count !== 16'((drops > 65535) ? 65535 : drops)) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d need %0d", illegal_count, drops);
    end
`else
    n_checks++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL rnd_drops: got %0d need 0", drops);
    end
`endif
    in_valid = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ack  = '0;
    in_valid = 3'b111;
    in_data  = {32'h33, 32'h22, 32'h11};
    tick();
    in_data = {32'h66, 32'h55, 32'h44};
    tick();
    n_checks++;
    if (in_ack !== 3'b000 || out_valid !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_full: got ack=%b v=%b need ack=000 v=111", in_ack, out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 3'b000 || in_ack !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_async: got v=%b ack=%b need v=000 ack=000", out_valid, in_ack);
    end
    in_valid = '0;
    tick();
    reset   = 1'b0;
    out_ack = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 3'b000) begin
        n_fail++;
        $display("FAIL mid_stale cyc%0d: got v=%b need 000", i, out_valid);
      end
    end
  endtask

  initial begin
    in_valid = '0;
    in_data  = '0;
    out_ack  = '0;
    test_reset();
    test_latency();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
